// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: LSU op encoding and the req/ack data-memory port between the memory stage and data memory.
package lsu_pkg;
  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;
endpackage

interface lsu_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  modport master(output req, we, addr, be, wdata, input ack, rdata);
  modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: memory-stage load/store controller turning one pipeline op into a req/ack transaction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing natural alignment.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  lsu_op_t       lsu_op,
  input  logic          mem_write,
  input  logic          mem_to_reg,
  input  logic [63:0]   addr,
  input  logic [63:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [63:0]   load_data,
  output logic          misaligned,
  output logic          bus_err,
  lsu_mem_ctrl_if.master mem
);
  localparam int CW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;
  state_t state;
  logic [1:0] size, size_r;
  logic [2:0] off, aoff, off_r;
  logic [7:0] be_n;
  logic [63:0] wd_n, sh, ext;
  logic accept, mis, mis_q, uns, uns_r, ld_r, tmo;
  logic [CW-1:0] cnt;
  assign off = addr[2:0];
  assign size = (lsu_op inside {LSU_LB, LSU_LBU, LSU_SB}) ? 2'd0 :
                (lsu_op inside {LSU_LH, LSU_LHU, LSU_SH}) ? 2'd1 :
                (lsu_op inside {LSU_LW, LSU_LWU, LSU_SW}) ? 2'd2 : 2'd3;
  assign uns = lsu_op inside {LSU_LBU, LSU_LHU, LSU_LWU};
  assign aoff = size == 2'd0 ? off : size == 2'd1 ? {off[2:1], 1'b0} :
                size == 2'd2 ? {off[2], 2'b00} : 3'd0;
  assign be_n = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF) << aoff;
  assign wd_n = size == 2'd0 ? {8{wdata[7:0]}} : size == 2'd1 ? {4{wdata[15:0]}} :
                size == 2'd2 ? {2{wdata[31:0]}} : wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  // an access is misaligned exactly when natural alignment would move its offset
  assign mis = aoff != off;
`else
  assign mis = 1'b0;
`endif
  assign misaligned = mis_q;
  assign accept = valid && lsu_op != LSU_NONE;
  assign stall = (state == IDLE && accept) || state == WAIT_ACK;
  assign sh = mem.rdata >> {off_r, 3'b000};
  assign ext = size_r == 2'd0 ? {{56{~uns_r & sh[7]}}, sh[7:0]} :
               size_r == 2'd1 ? {{48{~uns_r & sh[15]}}, sh[15:0]} :
               size_r == 2'd2 ? {{32{~uns_r & sh[31]}}, sh[31:0]} : sh;
  assign tmo = ACK_TIMEOUT != 0 && cnt == CW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      bus_err <= 1'b0;
      mis_q <= 1'b0;
      load_data <= '0;
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.addr <= '0;
      mem.be <= '0;
      mem.wdata <= '0;
      size_r <= '0;
      off_r <= '0;
      uns_r <= 1'b0;
      ld_r <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      bus_err <= 1'b0;
      mis_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mem.addr <= {addr[63:3], 3'b000};
          mem.be <= be_n;
          mem.wdata <= wd_n;
          mem.we <= mem_write;
          ld_r <= mem_to_reg;
          size_r <= size;
          uns_r <= uns;
          off_r <= aoff;
          cnt <= '0;
          load_data <= '0;
          state <= mis ? DONE : WAIT_ACK;
          mem.req <= !mis;
          done <= mis;
          mis_q <= mis;
        end
        WAIT_ACK: if (mem.ack || tmo) begin
          mem.req <= 1'b0;
          state <= DONE;
          done <= 1'b1;
          bus_err <= !mem.ack;
          load_data <= mem.ack && ld_r ? ext : 64'd0;
        end else if (cnt != CW'(ACK_TIMEOUT)) begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          load_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Memory-stage load/store controller that consumes the LSU control fields (`lsu_op`, `mem_write`, `mem_to_reg`) launched by the ID/EX pipeline register and carried into the memory stage. It turns one pipeline memory operation into a req/ack transaction on a 64-bit data-memory port and stalls the pipeline until the transaction completes. It returns sign- or zero-extended load data for writeback.

## Interface
- `ACK_TIMEOUT`, default 255: cycles in WAIT_ACK with no `mem_ack_i` before `bus_err_o` fires; 0 disables the timeout.
- `clk` in 1: core clock; all state is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `valid_i` in 1: a memory-stage instruction is present.
- `lsu_op_i` in `lsu_op_t`: one of LSU_NONE, LSU_LB/LH/LW/LD, LSU_LBU/LHU/LWU, LSU_SB/SH/SW/SD.
- `mem_write_i` in 1: store; must agree with `lsu_op_i` (store ops only).
- `mem_to_reg_i` in 1: load; must agree with `lsu_op_i` (load ops only).
- `addr_i` in 64: effective address from the ALU.
- `wdata_i` in 64: store data (rs2); the low bytes are used.
- `stall_o` out 1: hold IF/ID/EX and the memory-stage inputs stable.
- `done_o` out 1: one-cycle pulse when the operation completes.
- `load_data_o` out 64: extended load result; valid while `done_o`=1.
- `misaligned_o` out 1: one-cycle pulse for a misaligned access (only with the macro).
- `bus_err_o` out 1: one-cycle pulse on ack timeout.
- `mem_req_o` out 1: request to data memory.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out 64: doubleword-aligned address (`addr_i` with bits [2:0] cleared).
- `mem_be_o` out 8: byte enables.
- `mem_wdata_o` out 64: store data replicated into the byte lanes.
- `mem_ack_i` in 1: completes the request; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 64: read data, full doubleword.

## Operation
- FSM states: IDLE, WAIT_ACK, DONE.
- **IDLE**
  - A request is accepted when `valid_i` is high and `lsu_op_i` is not LSU_NONE.
  - On accept, the block registers the address, byte enables, write data, op and `we`, then moves to WAIT_ACK.
  - If the op is LSU_NONE, it stays in IDLE with no stall.
- **WAIT_ACK**
  - `mem_req_o`=1 and all memory outputs are held constant.
  - When `mem_ack_i` is seen, a load latches the extended data and the FSM moves to DONE.
  - On timeout, the FSM moves to DONE with `bus_err_o`=1 and `load_data_o`=0.
- **DONE**
  - `done_o`=1 and `stall_o`=0; the pipeline advances at the end of this cycle.
  - Inputs are ignored in this cycle; the next state is always IDLE.
- **Byte enables**, where off = `addr_i[2:0]`:
  - B: 1 << off.
  - H: 0x03 << off.
  - W: 0x0F << off.
  - D: 0xFF.
  - `mem_wdata_o` = `wdata_i` byte/half/word replicated across all lanes.
- **Load extraction**
  - Shift `mem_rdata_i` right by 8×off, then truncate to the access size.
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes through unchanged.
- **Store completion**: stores also complete through DONE; `load_data_o`=0 for stores.
- **Stray acks**: `mem_ack_i` outside WAIT_ACK is ignored.

## Timing
- `stall_o` = (IDLE & `valid_i` & op≠LSU_NONE) | WAIT_ACK.
  - This is combinational from the inputs in IDLE and registered otherwise.
- Accept happens in cycle 0. `mem_req_o` rises in cycle 1, registered.
- If the ack arrives in cycle N≥1, `done_o` and `load_data_o` are valid in cycle N+1.
  - Minimum latency: 3 cycles from accept to the pipeline advancing.
- Back-to-back operations: the next accept is possible in the cycle after DONE.
- Reset values:
  - State = IDLE.
  - `stall_o`, `done_o`, `misaligned_o`, `bus_err_o`, `mem_req_o`, `mem_we_o` = 0.
  - `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `load_data_o` = 0.
- Reset during WAIT_ACK drops `mem_req_o` immediately (asynchronously). The memory must tolerate the abandoned request.
- The timeout counter clears on every entry to WAIT_ACK and saturates at `ACK_TIMEOUT`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**: an access is misaligned when it is H with off[0]≠0, W with off[1:0]≠0, or D with off≠0.
  - In IDLE, a misaligned access issues no memory request; the FSM goes straight to DONE.
  - `misaligned_o` and `done_o` are 1 in the DONE cycle, and `load_data_o`=0.
  - `stall_o` is high in the accept cycle only.
- **Undefined**: the unused low offset bits are forced to natural alignment.
  - H uses {off[2:1],0}, W uses {off[2],00}, D uses 000.
  - `misaligned_o` is tied to 0.

## Test plan
- **LB sign-extend**: LB with `addr_i`=0x1003 and `mem_rdata_i`=0x00000000_80000000, ack in cycle 1.
  - `mem_addr_o`=0x1000 and `mem_be_o`=0x08.
  - `load_data_o`=0xFFFFFFFF_FFFFFF80 with `done_o` in cycle 2.
- **SH**: SH with `addr_i`=0x2006 and `wdata_i`=0xABCD.
  - `mem_we_o`=1, `mem_be_o`=0xC0, `mem_wdata_o`=0xABCDABCD_ABCDABCD.
  - `load_data_o`=0.
- **Late ack**: LWU with ack delayed 5 cycles and rdata high word 0x89ABCDEF at off=4.
  - `stall_o`=1 for cycles 0-6.
  - `load_data_o`=0x00000000_89ABCDEF.
- **Timeout**: with `ACK_TIMEOUT`=4 and no ack, `bus_err_o` and `done_o` pulse together and the FSM returns to IDLE.
- **Misaligned**: LW at 0x1002 with the macro defined gives `misaligned_o` and no `mem_req_o`. Without the macro, the access goes to `mem_be_o`=0x0F.
- **Reset mid-transaction**: assert `rst_n`=0 during WAIT_ACK.
  - `mem_req_o`=0 immediately.
  - After release the FSM is in IDLE, and a stray `mem_ack_i` produces no `done_o`.
